// File: rtl/edge_pkg.sv
// ============================================================================
// Module   : edge_pkg
// Brief    : Shared edge-mode encoding and logic-level constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package edge_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        BOTH = 2'd3
    } edge_mode_t;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

endpackage

`default_nettype wire

// File: rtl/edge_filter_channel.sv
// ============================================================================
// Module   : edge_filter_channel
// Brief    : One channel: debounce filter, edge pulses, sticky pending flag
//            and saturating event counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_filter_channel
    import edge_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   level,
    input  edge_mode_t             mode,
    input  logic                   clear,
    output logic                   filtered,
    output logic                   pos_edge,
    output logic                   neg_edge,
    output logic                   pending,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int STAB_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [STAB_W-1:0] C_STAB_LAST = STAB_W'(FILTER_CYCLES - 1);

    logic                   filtered_q, filtered_d;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic                   pos_edge_q, pos_edge_d;
    logic                   neg_edge_q, neg_edge_d;
    logic                   pending_q, pending_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   w_qualify;

    always_comb begin
        filtered_d = filtered_q;
        stab_d     = stab_q;
        pos_edge_d = 1'b0;
        neg_edge_d = 1'b0;
        if (level == filtered_q) begin
            stab_d = '0;
        end else if (stab_q == C_STAB_LAST) begin
            filtered_d = level;
            stab_d     = '0;
            pos_edge_d = (level == HIGH);
            neg_edge_d = (level == LOW);
        end else begin
            stab_d = stab_q + 1'b1;
        end
    end

    // Mode is sampled only while a pulse is present, so changing it never rewrites history.
    assign w_qualify = (pos_edge_q & ((mode == RISE) | (mode == BOTH)))
                     | (neg_edge_q & ((mode == FALL) | (mode == BOTH)));

    always_comb begin
        pending_d = (pending_q & ~clear) | w_qualify;
        count_d   = count_q;
        if (clear) begin
            count_d = w_qualify ? COUNT_WIDTH'(1) : '0;
        end else if (w_qualify && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filtered_q <= LOW;
            stab_q     <= '0;
            pos_edge_q <= 1'b0;
            neg_edge_q <= 1'b0;
            pending_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            filtered_q <= filtered_d;
            stab_q     <= stab_d;
            pos_edge_q <= pos_edge_d;
            neg_edge_q <= neg_edge_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
        end
    end

    assign filtered = filtered_q;
    assign pos_edge = pos_edge_q;
    assign neg_edge = neg_edge_q;
    assign pending  = pending_q;
    assign count    = count_q;

endmodule

`default_nettype wire

// File: rtl/edge_event_unit.sv
// ============================================================================
// Module   : edge_event_unit
// Brief    : Multi-channel edge-event block with a shared interrupt line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_event_unit
    import edge_pkg::*;
#(
    parameter int CHANNELS      = 8,
    parameter int FILTER_CYCLES = 4,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             level,
    input  logic [2*CHANNELS-1:0]           mode,
    input  logic [CHANNELS-1:0]             clear,
    output logic [CHANNELS-1:0]             filtered,
    output logic [CHANNELS-1:0]             pos_edge,
    output logic [CHANNELS-1:0]             neg_edge,
    output logic [CHANNELS-1:0]             pending,
    output logic [CHANNELS*COUNT_WIDTH-1:0] count,
    output logic                            irq
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_filter_channel #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .COUNT_WIDTH   (COUNT_WIDTH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .level    (level[i]),
            .mode     (edge_mode_t'(mode[2*i +: 2])),
            .clear    (clear[i]),
            .filtered (filtered[i]),
            .pos_edge (pos_edge[i]),
            .neg_edge (neg_edge[i]),
            .pending  (pending[i]),
            .count    (count[i*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

    assign irq = |pending;

endmodule

`default_nettype wire
